pipe_skid_stage: RTL

Parametrised elastic pipeline register placed between RV32I pipeline stages (F→D, D→E, and onward), carrying one packed stage bus such as `F_D_bus_t` (96 bits) or `D_E_bus_t` as a flat vector. It generalises the plain enable/clear stage register into a valid/ready handshake stage. A 2-entry skid buffer keeps `in_ready` fully registered, so back-pressure never forms a combinational path between stages. It also supports synchronous flush with bubble injection and an occupancy report.

---
 rtl/pipe_skid_stage_if.sv | 31 +++
 rtl/pipe_skid_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream valid/ready/data in,
// downstream valid/ready/data out. The slave modport is the stage's view,
// and the master modport is the view of whatever drives and drains it.
interface pipe_skid_stage_if #(
    parameter int DATA_WIDTH = 96
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic valid/ready register between pipeline stages.
// A main/skid register pair lets in_ready come straight from a flop, so
// downstream back-pressure never reaches upstream combinationally.
// Flush discards every held entry and reloads storage with BUBBLE_VALUE.
// Optional feature macro: PIPE_SKID_STATS_EN adds stall and flush counters.
module pipe_skid_stage #(
    parameter int                    DATA_WIDTH   = 96,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_skid_stage_if.slave     bus,
    output logic [1:0]           occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flushed_entries
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  in_fire;
    logic                  out_fire;

    assign in_fire       = bus.in_valid & in_ready_q;
    assign out_fire      = out_valid_q & bus.out_ready;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;

    // Next state and storage contents; flush overrides every normal move.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VALUE;
            skid_d  = BUBBLE_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d = ST_FULL;
                        skid_d  = bus.in_data;
                    end else if (out_fire && !in_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_VALUE;
                    end else if (in_fire && out_fire) begin
                        main_d  = bus.in_data;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VALUE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VALUE;
                    skid_d  = BUBBLE_VALUE;
                end
            endcase
        end
    end

    // State, storage and the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE_VALUE;
            skid_q      <= BUBBLE_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Occupancy decode from the current state.
    always_comb begin
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_WIDTH-1:0] stall_q;
    logic [CNT_WIDTH-1:0] flushed_q;
    logic [1:0]           flush_drop;

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic [1:0]           inc
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {{(CNT_WIDTH - 1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    // An entry leaving downstream in the flush cycle was delivered, not dropped.
    assign flush_drop = occupancy - {1'b0, out_fire};

    // Saturating statistics; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            if (bus.in_valid && !in_ready_q) begin
                stall_q <= sat_add(stall_q, 2'd1);
            end
            if (flush) begin
                flushed_q <= sat_add(flushed_q, flush_drop);
            end
        end
    end

    assign stall_cycles    = stall_q;
    assign flushed_entries = flushed_q;
`else
    logic unused_cnt_width;
    assign unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule
